// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit scheduler: FSM encoding and field widths.
package uart_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned GRANT_W = 3;

  localparam logic [2:0] ST_SLEEP   = 3'd0;
  localparam logic [2:0] ST_WAKE    = 3'd1;
  localparam logic [2:0] ST_IDLE    = 3'd2;
  localparam logic [2:0] ST_START   = 3'd3;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;
  localparam logic [2:0] ST_WAIT_LO = 3'd5;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid index at or above ptr_i, wrapping around.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  always_comb begin
    int unsigned j;
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr_i) + k) % NUM_REQ;
      if (!found_o && valid_i[j]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ byte producers, round-robin, with idle
// power-down of the UART and wake on demand.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned WAKE_CYCLES  = 4,
  parameter int unsigned IDLE_TIMEOUT = 1000,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic                      uart_en,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      err,
  output logic [2:0]                state
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned WakeW = $clog2(WAKE_CYCLES + 1);
  localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned BusyW = $clog2(BUSY_TIMEOUT + 1);

  logic [2:0]         state_d, state_q;
  logic               uart_en_d, uart_en_q;
  logic               tx_start_d, tx_start_q;
  logic [BYTE_W-1:0]  tx_data_d, tx_data_q;
  logic [NUM_REQ-1:0] req_ready_d, req_ready_q;
  logic [GRANT_W-1:0] grant_id_d, grant_id_q;
  logic               err_d, err_q;
  logic [IdxW-1:0]    rr_ptr_d, rr_ptr_q;
  logic [WakeW-1:0]   wake_cnt_d, wake_cnt_q;
  logic [IdleW-1:0]   idle_cnt_d, idle_cnt_q;
  logic [BusyW-1:0]   busy_cnt_d, busy_cnt_q;

  logic [IdxW-1:0]    arb_idx;
  logic               arb_found;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_arbiter (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (arb_idx),
    .found_o (arb_found)
  );

  always_comb begin
    state_d     = state_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    req_ready_d = '0;
    grant_id_d  = grant_id_q;
    err_d       = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    wake_cnt_d  = wake_cnt_q;
    // Idle counter only runs while sitting in IDLE; every other state parks it at zero.
    idle_cnt_d  = '0;
    busy_cnt_d  = busy_cnt_q;

    unique case (state_q)
      ST_SLEEP: begin
        if (|req_valid) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WakeW'(WAKE_CYCLES - 1);
        end
      end
      ST_WAKE: begin
        if (wake_cnt_q == '0) state_d = ST_IDLE;
        else                  wake_cnt_d = wake_cnt_q - 1'b1;
      end
      ST_IDLE: begin
        if (arb_found && !tx_busy) begin
          tx_data_d            = req_data[32'(arb_idx)*BYTE_W +: BYTE_W];
          grant_id_d           = GRANT_W'(arb_idx);
          req_ready_d[arb_idx] = 1'b1;
          rr_ptr_d             = IdxW'((32'(arb_idx) + 1) % NUM_REQ);
          state_d              = ST_START;
        end else begin
          idle_cnt_d = (idle_cnt_q != {IdleW{1'b1}}) ? idle_cnt_q + 1'b1 : idle_cnt_q;
          // A pending request (even one blocked by busy) always keeps the UART awake.
          if (!arb_found && idle_cnt_q >= IdleW'(IDLE_TIMEOUT - 1)) state_d = ST_SLEEP;
        end
      end
      ST_START: begin
        tx_start_d = 1'b1;
        busy_cnt_d = '0;
        state_d    = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end else if (busy_cnt_q == BusyW'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_SLEEP;
    endcase

    uart_en_d = (state_d != ST_SLEEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SLEEP;
      uart_en_q   <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      req_ready_q <= '0;
      grant_id_q  <= '0;
      err_q       <= 1'b0;
      rr_ptr_q    <= '0;
      wake_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      busy_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      uart_en_q   <= uart_en_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      req_ready_q <= req_ready_d;
      grant_id_q  <= grant_id_d;
      err_q       <= err_d;
      rr_ptr_q    <= rr_ptr_d;
      wake_cnt_q  <= wake_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign state     = state_q;
  assign uart_en   = uart_en_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign req_ready = req_ready_q;
  assign grant_id  = grant_id_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: wake, round-robin contention, idle sleep, busy
// timeout, mid-frame reset and request-at-timeout-edge.
module tb_uart_tx_sched;

  localparam int unsigned BUSY_LEN = 4;

  localparam logic [2:0] S_SLEEP   = 3'd0;
  localparam logic [2:0] S_WAKE    = 3'd1;
  localparam logic [2:0] S_IDLE    = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;
  localparam logic [2:0] S_WAIT_LO = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        uart_en;
  logic [2:0]  grant_id;
  logic        err;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  logic uart_never_busy = 1'b0;
  int   busy_left = 0;
  logic saw_busy;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .NUM_REQ      (2),
    .WAKE_CYCLES  (4),
    .IDLE_TIMEOUT (20),
    .BUSY_TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .uart_en   (uart_en),
    .grant_id  (grant_id),
    .err       (err),
    .state     (state)
  );

  // UART model: busy for BUSY_LEN cycles starting the cycle after tx_start.
  always @(posedge clk) begin
    if (tx_start && !uart_never_busy) begin
      tx_busy   <= 1'b1;
      busy_left <= BUSY_LEN - 1;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    n_checks++;
    if (obs !== exp_val) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(state), 32'(s));
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    saw_busy = 1'b0;
    while (req_ready === 2'b00 && n < budget) begin
      @(negedge clk);
      if (tx_busy) saw_busy = 1'b1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_data  = 16'h0000;
    tick(2);
    check_eq("rst_state",    32'(state),     32'(S_SLEEP));
    check_eq("rst_uart_en",  32'(uart_en),   32'd0);
    check_eq("rst_tx_start", 32'(tx_start),  32'd0);
    check_eq("rst_tx_data",  32'(tx_data),   32'h00);
    check_eq("rst_ready",    32'(req_ready), 32'd0);
    check_eq("rst_grant",    32'(grant_id),  32'd0);
    check_eq("rst_err",      32'(err),       32'd0);
    rst_n = 1'b1;
    tick(2);
    check_eq("sleep_hold", 32'(state), 32'(S_SLEEP));

    // 1: single request with wake-up
    req_valid = 2'b01;
    req_data[7:0] = 8'hA5;
    tick(1);
    check_eq("t1_wake",    32'(state),   32'(S_WAKE));
    check_eq("t1_en",      32'(uart_en), 32'd1);
    tick(3);
    check_eq("t1_wake4",   32'(state),   32'(S_WAKE));
    tick(1);
    check_eq("t1_idle",    32'(state),   32'(S_IDLE));
    check_eq("t1_noready", 32'(req_ready), 32'd0);
    tick(1);
    check_eq("t1_ready",   32'(req_ready), 32'b01);
    check_eq("t1_start_state", 32'(state), 32'(S_START));
    check_eq("t1_data",    32'(tx_data), 32'hA5);
    check_eq("t1_grant",   32'(grant_id), 32'd0);
    req_valid = 2'b00;
    tick(1);
    check_eq("t1_txstart", 32'(tx_start),  32'd1);
    check_eq("t1_ready_pulse", 32'(req_ready), 32'd0);
    tick(1);
    check_eq("t1_txstart_pulse", 32'(tx_start), 32'd0);
    wait_state(S_WAIT_LO, 20, "t1_wait_lo");
    check_eq("t1_data_hold", 32'(tx_data), 32'hA5);
    wait_state(S_IDLE, 20, "t1_done");
    check_eq("t1_data_after", 32'(tx_data), 32'hA5);

    // 2: contention from a fresh reset (rr pointer at 0)
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    req_valid = 2'b11;
    req_data  = {8'h3C, 8'hA5};
    wait_ready(40);
    check_eq("t2_ready0", 32'(req_ready), 32'b01);
    check_eq("t2_grant0", 32'(grant_id),  32'd0);
    check_eq("t2_data0",  32'(tx_data),   32'hA5);
    req_valid[0] = 1'b0;
    tick(1);
    check_eq("t2_start0", 32'(tx_start), 32'd1);
    tick(1);
    wait_ready(40);
    check_eq("t2_ready1", 32'(req_ready), 32'b10);
    check_eq("t2_grant1", 32'(grant_id),  32'd1);
    check_eq("t2_data1",  32'(tx_data),   32'h3C);
    check_eq("t2_busy_between", 32'(saw_busy), 32'd1);
    check_eq("t2_busy_low", 32'(tx_busy), 32'd0);
    req_valid[1] = 1'b0;
    tick(1);
    check_eq("t2_start1", 32'(tx_start), 32'd1);
    wait_state(S_WAIT_LO, 20, "t2_wait_lo");
    wait_state(S_IDLE, 20, "t2_done");

    // 3: idle timeout into sleep, then re-wake
    tick(19);
    check_eq("t3_idle19",  32'(state),   32'(S_IDLE));
    check_eq("t3_en19",    32'(uart_en), 32'd1);
    tick(1);
    check_eq("t3_sleep",   32'(state),   32'(S_SLEEP));
    check_eq("t3_en_off",  32'(uart_en), 32'd0);
    req_valid = 2'b01;
    req_data[7:0] = 8'h5A;
    tick(1);
    check_eq("t3_wake",    32'(state),   32'(S_WAKE));
    tick(3);
    check_eq("t3_wake4",   32'(state),   32'(S_WAKE));
    tick(1);
    check_eq("t3_idle",    32'(state),   32'(S_IDLE));
    tick(1);
    check_eq("t3_ready",   32'(req_ready), 32'b01);
    check_eq("t3_data",    32'(tx_data),   32'h5A);
    req_valid = 2'b00;
    wait_state(S_WAIT_LO, 20, "t3_wait_lo");
    wait_state(S_IDLE, 20, "t3_done");

    // 4: UART never raises busy
    uart_never_busy = 1'b1;
    req_valid = 2'b01;
    req_data[7:0] = 8'hC3;
    tick(1);
    check_eq("t4_ready", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    tick(1);
    check_eq("t4_start", 32'(tx_start), 32'd1);
    tick(15);
    check_eq("t4_no_err_early", 32'(err),   32'd0);
    check_eq("t4_wait_hi",      32'(state), 32'(S_WAIT_HI));
    tick(1);
    check_eq("t4_err",      32'(err),   32'd1);
    check_eq("t4_idle",     32'(state), 32'(S_IDLE));
    uart_never_busy = 1'b0;
    req_valid = 2'b10;
    req_data[15:8] = 8'h77;
    tick(1);
    check_eq("t4_err_pulse", 32'(err),       32'd0);
    check_eq("t4_ready1",    32'(req_ready), 32'b10);
    check_eq("t4_grant1",    32'(grant_id),  32'd1);
    check_eq("t4_data1",     32'(tx_data),   32'h77);
    req_valid = 2'b00;
    wait_state(S_WAIT_LO, 20, "t4_wait_lo");
    wait_state(S_IDLE, 20, "t4_done");

    // 5: reset during WAIT_LO, request stays presented
    req_valid = 2'b01;
    req_data[7:0] = 8'hE1;
    wait_state(S_WAIT_LO, 20, "t5_wait_lo");
    rst_n = 1'b0;
    #1;
    check_eq("t5_state",  32'(state),    32'(S_SLEEP));
    check_eq("t5_en",     32'(uart_en),  32'd0);
    check_eq("t5_start",  32'(tx_start), 32'd0);
    check_eq("t5_data",   32'(tx_data),  32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(60);
    check_eq("t5_reaccept", 32'(req_ready), 32'b01);
    check_eq("t5_data2",    32'(tx_data),   32'hE1);
    req_valid = 2'b00;
    wait_state(S_WAIT_LO, 20, "t5_wait_lo2");
    wait_state(S_IDLE, 20, "t5_done");

    // 6: request arrives on the timeout cycle
    tick(19);
    check_eq("t6_idle19", 32'(state), 32'(S_IDLE));
    req_valid = 2'b10;
    req_data[15:8] = 8'hB4;
    tick(1);
    check_eq("t6_ready",  32'(req_ready), 32'b10);
    check_eq("t6_state",  32'(state),     32'(S_START));
    check_eq("t6_en",     32'(uart_en),   32'd1);
    check_eq("t6_data",   32'(tx_data),   32'hB4);
    req_valid = 2'b00;
    wait_state(S_WAIT_LO, 20, "t6_wait_lo");
    wait_state(S_IDLE, 20, "t6_done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one low-power UART transmitter (tx_start/data_in/busy interface) between NUM_REQ byte producers. It accepts a byte from one requester at a time and issues a one-cycle start pulse. It then tracks the UART's busy flag to frame completion. After an idle timeout it drops the UART enable so the transmitter can be clock-gated, and it wakes the transmitter on demand.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
WAKE_CYCLES, 4, cycles from uart_en rise to first tx_start (>=1)
IDLE_TIMEOUT, 1000, consecutive idle cycles in IDLE before entering SLEEP (>=1)
BUSY_TIMEOUT, 16, max cycles from tx_start to tx_busy rising before error (>=1)

Ports:
clk  input  1  system clock (50 MHz nominal)
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  8*NUM_REQ  byte i at [8*i+7:8*i]
req_ready  output  NUM_REQ  one-hot one-cycle accept pulse
tx_start  output  1  one-cycle start pulse to UART
tx_data  output  8  byte to UART; stable from START through WAIT_LO
tx_busy  input  1  UART busy flag
uart_en  output  1  UART power/clock enable
grant_id  output  3  index of last accepted requester
err  output  1  one-cycle pulse on busy timeout
state  output  3  current FSM state (debug)

Behaviour:
- Reset (async, rst_n=0): state=SLEEP; tx_start=0, tx_data=0, req_ready=0, uart_en=0, grant_id=0, err=0. RR pointer=0; all counters=0. A reset mid-frame aborts the frame immediately.
- All outputs are registered. State encoding is SLEEP=0, WAKE=1, IDLE=2, START=3, WAIT_HI=4, WAIT_LO=5.
- SLEEP: uart_en=0. If |req_valid, go to WAKE next cycle, set uart_en=1, and load wake_cnt=WAKE_CYCLES-1.
- WAKE: uart_en=1. Decrement wake_cnt each cycle. When wake_cnt==0, go to IDLE. req_valid dropping during WAKE does not abort the wake.
- IDLE, request present: if |req_valid and tx_busy==0, select the first valid index searching from rr_ptr upward with wrap. In the same cycle:
  - register tx_data=req_data[i] and grant_id=i;
  - pulse req_ready[i]=1 for one cycle;
  - set rr_ptr=(i+1) mod NUM_REQ;
  - clear idle_cnt;
  - go to START.
- IDLE, no request: if no request, or tx_busy==1, increment idle_cnt (saturating). When idle_cnt reaches IDLE_TIMEOUT-1 with no valid request, go to SLEEP and set uart_en=0 on the next cycle. A request in the same cycle as the timeout wins, and no sleep occurs.
- START: tx_start=1 for exactly this one cycle. Load busy_cnt=0 and go to WAIT_HI.
- WAIT_HI:
  - tx_busy==1: go to WAIT_LO.
  - Otherwise increment busy_cnt. When busy_cnt==BUSY_TIMEOUT-1, pulse err for one cycle and return to IDLE (byte dropped).
- WAIT_LO: hold until tx_busy==0, then go to IDLE.
- Requester protocol: req_valid and req_data must stay stable until req_ready. A requester must not lower valid before acceptance. Simultaneous valids resolve by round-robin, so a requester is never granted twice while another is continuously valid.
- Acceptance throughput: at most one acceptance per UART frame. The minimum gap is 3 cycles plus the busy duration.
- uart_en=1 in every state except SLEEP.
- Width rules:
  - idle_cnt width: $clog2(IDLE_TIMEOUT+1).
  - busy_cnt width: $clog2(BUSY_TIMEOUT+1).
  - grant_id is zero-extended to 3 bits.

Decomposition:
- Shared package uart_pkg: state encoding constants (ST_SLEEP..ST_WAIT_LO), byte width constant 8, and grant_id width 3.
- One sub-module, rr_arbiter (NUM_REQ-wide rotate/priority-encode returning index and found flag), kept combinational. The FSM and counters stay in uart_tx_sched.

Test Plan:
1. Reset then single request: after release, req_valid=2'b01, data 8'hA5. Expect WAKE for 4 cycles, then IDLE, then req_ready=2'b01 pulse, tx_start pulse next cycle, and tx_data=8'hA5 held until busy falls.
2. Contention: both valid, req0=8'hA5 and req1=8'h3C, held until accepted. Expect grants in order 0 then 1 (grant_id 0, then 1). Each has one start pulse, and the second start comes only after busy falls from frame 1.
3. Idle sleep: with IDLE_TIMEOUT=20, no requests after one frame. Expect uart_en=0 and state=0 exactly 20 cycles after entering IDLE. A new request then re-wakes with a 4-cycle WAKE.
4. Busy timeout: UART model never raises busy. Expect an err pulse 16 cycles after tx_start, return to IDLE, and the next request accepted normally.
5. Reset mid-frame: assert rst_n=0 during WAIT_LO. Expect immediate uart_en=0, tx_start=0, state=0, tx_data=0. After release, the same request is re-accepted.
6. Request at timeout edge: req_valid rises on the cycle idle_cnt==IDLE_TIMEOUT-1. Expect acceptance (req_ready pulse) and no SLEEP entry.
